// File: rtl/bus_pkg.sv
// Shared bus definitions: packet type, broadcast ID and destination-field accessor.
// Also used by the bus generator library.
package bus_pkg;
   localparam int         PKT_W    = 16;
   localparam logic [7:0] BCAST_ID = 8'hFF;

   typedef logic [PKT_W-1:0] pkt_t;

   function automatic logic [7:0] get_dest(pkt_t p);
      return p[PKT_W-1 -: 8];
   endfunction
endpackage

// File: rtl/bus_rx_port_if.sv
// Bus-side push beats plus device-side valid/ready output of one receive port.
interface bus_rx_port_if #(parameter int PCKG_SZ = 16);
   logic               push;
   logic [PCKG_SZ-1:0] D_push;
   logic [PCKG_SZ-1:0] dout;
   logic               dout_valid;
   logic               dout_ready;

   modport master (output push, D_push, dout_ready, input dout, dout_valid);
   modport slave  (input push, D_push, dout_ready, output dout, dout_valid);
endinterface

// File: rtl/bus_rx_fifo.sv
// First-word-fall-through FIFO; dout is registered and keeps the last packet while empty.
module bus_rx_fifo #(
   parameter int PCKG_SZ = 16,
   parameter int DEPTH   = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [PCKG_SZ-1:0] din,
   input  logic               rd_en,
   output logic [PCKG_SZ-1:0] dout,
   output logic [AW:0]        level,
   output logic               full,
   output logic               empty
);
   logic [PCKG_SZ-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr, rd_ptr_nx, wr_ptr_nx, level_nx;
   logic [AW-1:0]      wr_addr, rd_addr_nx;

   assign wr_addr    = wr_ptr[AW-1:0];
   assign rd_ptr_nx  = rd_ptr + {{AW{1'b0}}, rd_en};
   assign wr_ptr_nx  = wr_ptr + {{AW{1'b0}}, wr_en};
   assign rd_addr_nx = rd_ptr_nx[AW-1:0];
   assign level_nx   = wr_ptr_nx - rd_ptr_nx;

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= din;
   end

   // A write into the slot that becomes the head must bypass the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr_nx;
         rd_ptr <= rd_ptr_nx;
         if (level_nx != '0)
            dout <= (wr_en && (wr_addr == rd_addr_nx)) ? din : mem[rd_addr_nx];
      end
   end
endmodule

// File: rtl/bus_rx_port.sv
// Receive endpoint: destination filter, packet FIFO, statistics counters and sticky error flags.
module bus_rx_port import bus_pkg::*; #(
   parameter int         PCKG_SZ = 16,
   parameter logic [7:0] DEV_ID  = 8'd0,
   parameter logic [7:0] BCAST   = BCAST_ID,
   parameter int         DEPTH   = 8,
   parameter int         CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   bus_rx_port_if.slave             bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic [CNT_W-1:0]         rx_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [CNT_W-1:0]         miss_cnt,
   output logic                     ovf_err,
   output logic                     id_err,
   input  logic                     err_clr
);
   logic [7:0] dest;
   logic       match, pop_now, wr_en, ovf_evt, miss_evt, empty;

   assign dest     = bus.D_push[PCKG_SZ-1 -: 8];
   assign match    = (dest == DEV_ID) || (dest == BCAST);
   assign pop_now  = bus.dout_valid && bus.dout_ready;
   // A pop on the same edge frees the slot the incoming packet needs.
   assign wr_en    = bus.push && match && (!full || pop_now);
   assign ovf_evt  = bus.push && match && full && !pop_now;
   assign miss_evt = bus.push && !match;

   assign bus.dout_valid = !empty;

   bus_rx_fifo #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .wr_en (wr_en),
      .din   (bus.D_push),
      .rd_en (pop_now),
      .dout  (bus.dout),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_cnt   <= '0;
         drop_cnt <= '0;
         miss_cnt <= '0;
         ovf_err  <= 1'b0;
         id_err   <= 1'b0;
      end else begin
         if (wr_en)    rx_cnt   <= rx_cnt + 1'b1;
         if (ovf_evt)  drop_cnt <= drop_cnt + 1'b1;
         if (miss_evt) miss_cnt <= miss_cnt + 1'b1;
         // A new event in the clearing cycle wins over err_clr.
         if (ovf_evt)      ovf_err <= 1'b1;
         else if (err_clr) ovf_err <= 1'b0;
         if (miss_evt)     id_err  <= 1'b1;
         else if (err_clr) id_err  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bus_rx_port.sv
// Bench for bus_rx_port: four ports (IDs 0..3) share one bus; port 2 is tracked by a queue model.
module tb_bus_rx_port;
   localparam int MY = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        push = 1'b0;
   logic [15:0] d_push = '0;
   logic        dout_ready = 1'b0;
   logic        err_clr = 1'b0;

   logic [15:0] dout_a  [4];
   logic        vld_a   [4];
   logic [3:0]  level_a [4];
   logic        full_a  [4];
   logic [15:0] rx_a    [4];
   logic [15:0] drop_a  [4];
   logic [15:0] miss_a  [4];
   logic        ovf_a   [4];
   logic        id_a    [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_port
      bus_rx_port_if #(.PCKG_SZ(16)) bif ();
      assign bif.push       = push;
      assign bif.D_push     = d_push;
      assign bif.dout_ready = dout_ready;
      bus_rx_port #(.PCKG_SZ(16), .DEV_ID(8'(g)), .BCAST(8'hFF), .DEPTH(8), .CNT_W(16)) dut (
         .clk(clk), .reset(reset), .bus(bif), .level(level_a[g]), .full(full_a[g]),
         .rx_cnt(rx_a[g]), .drop_cnt(drop_a[g]), .miss_cnt(miss_a[g]),
         .ovf_err(ovf_a[g]), .id_err(id_a[g]), .err_clr(err_clr));
      assign dout_a[g] = bif.dout;
      assign vld_a[g]  = bif.dout_valid;
   end

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model of port 2
   logic [15:0] mq[$];
   logic [15:0] m_rx = '0, m_drop = '0, m_miss = '0;
   bit          m_ovf = 0, m_id = 0;

   task automatic model_clear();
      mq.delete();
      m_rx = '0; m_drop = '0; m_miss = '0; m_ovf = 0; m_id = 0;
   endtask

   task automatic step(input logic p, input logic [15:0] d, input logic r, input logic c);
      int  pre;
      bit  pop, match, ovf, miss;
      push = p; d_push = d; dout_ready = r; err_clr = c;
      @(posedge clk);
      pre   = mq.size();
      pop   = r && (pre > 0);
      match = (d[15:8] == 8'(MY)) || (d[15:8] == 8'hFF);
      ovf   = 0;
      miss  = 0;
      if (pop) void'(mq.pop_front());
      if (p && match) begin
         if (pre < 8 || pop) begin mq.push_back(d); m_rx++; end
         else begin m_drop++; ovf = 1; end
      end
      if (p && !match) begin m_miss++; miss = 1; end
      if (ovf) m_ovf = 1; else if (c) m_ovf = 0;
      if (miss) m_id = 1; else if (c) m_id = 0;
      #1;
      push = 1'b0; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      tests_run++; if (vld_a[MY] !== 1'b0 || level_a[MY] !== 4'd0 || full_a[MY] !== 1'b0 || dout_a[MY] !== 16'h0)
         begin tests_failed++; $display("FAIL por_state: vld=%b level=%0d full=%b dout=%h want 0/0/0/0000", vld_a[MY], level_a[MY], full_a[MY], dout_a[MY]); end
      @(posedge clk); #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0230 + 16'(i), 1'b0, 1'b0);
      tests_run++; if (level_a[MY] !== 4'd3)
         begin tests_failed++; $display("FAIL pre_rst_level: got %0d want 3", level_a[MY]); end
      #2 reset = 1'b0;
      #1;
      tests_run++; if (vld_a[MY] !== 1'b0 || level_a[MY] !== 4'd0 || dout_a[MY] !== 16'h0)
         begin tests_failed++; $display("FAIL async_rst: vld=%b level=%0d dout=%h want 0/0/0000", vld_a[MY], level_a[MY], dout_a[MY]); end
      tests_run++; if (rx_a[MY] !== 16'd0 || drop_a[MY] !== 16'd0 || miss_a[MY] !== 16'd0 || ovf_a[MY] !== 1'b0 || id_a[MY] !== 1'b0)
         begin tests_failed++; $display("FAIL async_rst_cnt: rx=%0d drop=%0d miss=%0d ovf=%b id=%b want all 0", rx_a[MY], drop_a[MY], miss_a[MY], ovf_a[MY], id_a[MY]); end
      model_clear();
      push = 1'b1; d_push = 16'h0299;
      repeat (2) @(posedge clk);
      #1 push = 1'b0;
      tests_run++; if (rx_a[MY] !== 16'd0 || level_a[MY] !== 4'd0 || miss_a[0] !== 16'd0)
         begin tests_failed++; $display("FAIL push_in_rst: rx=%0d level=%0d miss0=%0d want 0/0/0", rx_a[MY], level_a[MY], miss_a[0]); end
      reset = 1'b1;
   endtask

   task automatic test_match();
      do_reset();
      step(1'b1, 16'h02AB, 1'b0, 1'b0);
      tests_run++; if (dout_a[MY] !== 16'h02AB || vld_a[MY] !== 1'b1 || rx_a[MY] !== 16'd1)
         begin tests_failed++; $display("FAIL match_accept: dout=%h vld=%b rx=%0d want 02ab/1/1", dout_a[MY], vld_a[MY], rx_a[MY]); end
      step(1'b1, 16'h03CD, 1'b0, 1'b0);
      tests_run++; if (miss_a[MY] !== 16'd1 || id_a[MY] !== 1'b1 || level_a[MY] !== 4'd1)
         begin tests_failed++; $display("FAIL foreign_id: miss=%0d id_err=%b level=%0d want 1/1/1", miss_a[MY], id_a[MY], level_a[MY]); end
      tests_run++; if (rx_a[3] !== 16'd1 || miss_a[3] !== 16'd1)
         begin tests_failed++; $display("FAIL port3_counts: rx=%0d miss=%0d want 1/1", rx_a[3], miss_a[3]); end
      step(1'b0, 16'h0, 1'b0, 1'b1);
      tests_run++; if (id_a[MY] !== 1'b0 || dout_a[MY] !== 16'h02AB)
         begin tests_failed++; $display("FAIL id_clr: id_err=%b dout=%h want 0/02ab", id_a[MY], dout_a[MY]); end
   endtask

   task automatic test_broadcast();
      do_reset();
      step(1'b1, 16'hFF11, 1'b0, 1'b0);
      for (int g = 0; g < 4; g++) begin
         tests_run++; if (rx_a[g] !== 16'd1 || vld_a[g] !== 1'b1 || dout_a[g] !== 16'hFF11 || miss_a[g] !== 16'd0)
            begin tests_failed++; $display("FAIL bcast_port%0d: rx=%0d vld=%b dout=%h miss=%0d want 1/1/ff11/0", g, rx_a[g], vld_a[g], dout_a[g], miss_a[g]); end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      tests_run++; if (level_a[MY] !== 4'd8 || full_a[MY] !== 1'b1 || drop_a[MY] !== 16'd1 || ovf_a[MY] !== 1'b1 || rx_a[MY] !== 16'd8)
         begin tests_failed++; $display("FAIL overflow: level=%0d full=%b drop=%0d ovf=%b rx=%0d want 8/1/1/1/8", level_a[MY], full_a[MY], drop_a[MY], ovf_a[MY], rx_a[MY]); end
      tests_run++; if (dout_a[MY] !== 16'h0200)
         begin tests_failed++; $display("FAIL overflow_head: dout=%h want 0200", dout_a[MY]); end
      step(1'b0, 16'h0, 1'b0, 1'b1);
      tests_run++; if (ovf_a[MY] !== 1'b0)
         begin tests_failed++; $display("FAIL ovf_clr: ovf_err=%b want 0", ovf_a[MY]); end
      step(1'b1, 16'h02EE, 1'b0, 1'b1);
      tests_run++; if (ovf_a[MY] !== 1'b1 || drop_a[MY] !== 16'd2)
         begin tests_failed++; $display("FAIL clr_vs_event: ovf_err=%b drop=%0d want 1/2", ovf_a[MY], drop_a[MY]); end
   endtask

   task automatic test_full_push_pop();
      logic [15:0] last;
      last = '0;
      step(1'b1, 16'h0277, 1'b1, 1'b0);
      tests_run++; if (level_a[MY] !== 4'd8 || drop_a[MY] !== m_drop || rx_a[MY] !== m_rx)
         begin tests_failed++; $display("FAIL full_push_pop: level=%0d drop=%0d rx=%0d want 8/%0d/%0d", level_a[MY], drop_a[MY], rx_a[MY], m_drop, m_rx); end
      for (int n = 0; n < 12 && mq.size() > 0; n++) begin
         tests_run++; if (vld_a[MY] !== 1'b1 || dout_a[MY] !== mq[0])
            begin tests_failed++; $display("FAIL drain_order: vld=%b dout=%h want 1/%h", vld_a[MY], dout_a[MY], mq[0]); end
         last = dout_a[MY];
         step(1'b0, 16'h0, 1'b1, 1'b0);
      end
      tests_run++; if (last !== 16'h0277 || vld_a[MY] !== 1'b0 || level_a[MY] !== 4'd0 || dout_a[MY] !== 16'h0277)
         begin tests_failed++; $display("FAIL drain_end: last=%h vld=%b level=%0d dout=%h want 0277/0/0/0277", last, vld_a[MY], level_a[MY], dout_a[MY]); end
   endtask

   task automatic test_wrap();
      logic [15:0] sent[$];
      logic [15:0] got[$];
      logic [15:0] d;
      logic        r;
      int          errs;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         r = (mq.size() >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (vld_a[MY] && r) got.push_back(dout_a[MY]);
         d = {8'h02, 8'($urandom)};
         sent.push_back(d);
         step(1'b1, d, r, 1'b0);
         tests_run++; if (level_a[MY] !== 4'(mq.size()) || vld_a[MY] !== (mq.size() > 0) || (mq.size() > 0 && dout_a[MY] !== mq[0]))
            begin tests_failed++; $display("FAIL wrap_step%0d: level=%0d vld=%b dout=%h want level %0d", i, level_a[MY], vld_a[MY], dout_a[MY], mq.size()); end
      end
      for (int n = 0; n < 40 && mq.size() > 0; n++) begin
         r = $urandom_range(0, 1);
         if (vld_a[MY] && r) got.push_back(dout_a[MY]);
         step(1'b0, 16'h0, r, 1'b0);
      end
      errs = 0;
      for (int i = 0; i < 20; i++) if (i >= got.size() || got[i] !== sent[i]) errs++;
      tests_run++; if (errs != 0 || got.size() != 20)
         begin tests_failed++; $display("FAIL wrap_order: %0d mismatched of %0d received, want 0 of 20", errs, got.size()); end
      tests_run++; if (rx_a[MY] !== 16'd20 || level_a[MY] !== 4'd0 || drop_a[MY] !== 16'd0)
         begin tests_failed++; $display("FAIL wrap_end: rx=%0d level=%0d drop=%0d want 20/0/0", rx_a[MY], level_a[MY], drop_a[MY]); end
   endtask

   initial begin
      test_reset();
      test_match();
      test_broadcast();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1);
   end
endmodule
